// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, size codes,
// byte counts and load extension.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10
    } state_e;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_ILLEGAL = 2'b10;
    localparam logic [1:0] SZ_WORD    = 2'b11;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] size,
                                             input logic sgn);
        case (size)
            SZ_BYTE: load_ext = {{24{sgn & rd[7]}}, rd[7:0]};
            SZ_HALF: load_ext = {{16{sgn & rd[15]}}, rd[15:0]};
            default: load_ext = rd;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the last-grant register advances on each accept pulse.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (accept_i) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for data_memory.
// Define DMEM_ARBITER_ALIGN_CHECK_EN to also reject misaligned half/word accesses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_BYTES  = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_we,
    input  logic [1:0]                 req_signed,
    input  logic [1:0][1:0]            req_size,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [1:0]                 mem_size,
    output logic [DATA_WIDTH-1:0]      mem_wd,
    input  logic [DATA_WIDTH-1:0]      mem_rd
);

    localparam int unsigned AW1 = ADDR_WIDTH + 1;

    state_e                  state_q;
    logic                    we_q, sgn_q, owner_q;
    logic [1:0]              size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [1:0]              rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic [1:0]              gnt;
    logic                    accept;
    logic                    owner_d;
    logic [ADDR_WIDTH:0]     end_addr;
    logic                    err;

    rr_arbiter2 u_rr (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req_valid & {2{state_q == StIdle}}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign req_ready = rst_n ? gnt : 2'b00;
    assign accept    = |req_ready;
    assign owner_d   = req_ready[1];

    assign end_addr = {1'b0, addr_q} + AW1'(size_bytes(size_q));

    always_comb begin
        err = (size_q == SZ_ILLEGAL) || (end_addr > AW1'(MEM_BYTES));
`ifdef DMEM_ARBITER_ALIGN_CHECK_EN
        if ((size_q == SZ_HALF && addr_q[0]) || (size_q == SZ_WORD && addr_q[1:0] != 2'b00)) begin
            err = 1'b1;
        end
`endif
    end

    // Gated by rst_n so a reset landing in ACCESS suppresses the write on that edge.
    assign mem_we    = rst_n && (state_q == StAccess) && we_q && !err;
    assign mem_addr  = addr_q;
    assign mem_size  = size_q;
    assign mem_wd    = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            owner_q     <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        we_q    <= req_we[owner_d];
                        sgn_q   <= req_signed[owner_d];
                        size_q  <= req_size[owner_d];
                        addr_q  <= req_addr[owner_d];
                        wdata_q <= req_wdata[owner_d];
                        owner_q <= owner_d;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    rsp_err_q   <= err;
                    rsp_rdata_q <= (err || we_q) ? '0 : load_ext(mem_rd, size_q, sgn_q);
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= StResp;
                end
                StResp: begin
                    rsp_valid_q <= 2'b00;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed and random accesses against a byte-array model.
module tb_dmem_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid, req_ready, req_we, req_signed, rsp_valid;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_addr, req_wdata;
    logic [31:0]      rsp_rdata, mem_addr, mem_wd, mem_rd;
    logic             rsp_err, mem_we;
    logic [1:0]       mem_size;

    logic [7:0] m       [256];
    logic [7:0] ref_mem [256];
    bit         mem_init;
    int         we_pulses = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    dmem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_signed (req_signed),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_size   (mem_size),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    // Memory model: combinational read, byte-lane write on the clock edge.
    always_comb begin
        mem_rd = '0;
        for (int i = 0; i < 4; i++)
            if ({32'd0, mem_addr} + 64'(i) < 64'd256) mem_rd[8*i +: 8] = m[mem_addr[7:0] + 8'(i)];
    end

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) m[i] <= 8'h00;
            mem_init <= 1'b1;
        end else if (mem_we) begin
            for (int i = 0; i < nbytes(mem_size); i++)
                if ({32'd0, mem_addr} + 64'(i) < 64'd256) m[mem_addr[7:0] + 8'(i)] <= mem_wd[8*i +: 8];
        end
    end

    always @(posedge clk) if (mem_we === 1'b1) we_pulses++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: access outcome from the architectural rules on a flat byte array.
    task automatic ref_access(input logic we, input logic sgn, input logic [1:0] sz,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
        int  nb;
        longint v;
        nb    = nbytes(sz);
        err   = (nb == 0) || (longint'(addr) + longint'(nb) > 256);
`ifdef DMEM_ARBITER_ALIGN_CHECK_EN
        if ((nb == 2 && addr % 2 != 0) || (nb == 4 && addr % 4 != 0)) err = 1'b1;
`endif
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v + (longint'(ref_mem[addr + i]) << (8 * i));
                if (sgn && nb < 4 && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
                rdata = v[31:0];
            end
        end
    endtask

    // One full transaction from requester r; called at a negedge with the DUT idle.
    task automatic xact(input int r, input logic we, input logic sgn, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] er;
        logic        ee;
        int          p0;
        int          waitc;
        ref_access(we, sgn, sz, addr, wdata, er, ee);
        req_we[r]     = we;
        req_signed[r] = sgn;
        req_size[r]   = sz;
        req_addr[r]   = addr;
        req_wdata[r]  = wdata;
        req_valid[r]  = 1'b1;
        waitc = 0;
        #1;
        while (req_ready[r] !== 1'b1 && waitc < 8) begin
            @(negedge clk); #1;
            waitc++;
        end
        check("grant", 64'(req_ready), 64'(2'b01 << r));
        p0 = we_pulses;
        @(negedge clk);
        req_valid[r] = 1'b0;
        #1;
        check("access_we", 64'(mem_we), 64'(we && !ee));
        check("access_ready", 64'(req_ready), 64'd0);
        check("access_rsp", 64'(rsp_valid), 64'd0);
        if (!ee) check("access_addr", 64'(mem_addr), 64'(addr));
        @(negedge clk); #1;
        check("rsp_valid", 64'(rsp_valid), 64'(2'b01 << r));
        check("rsp_err", 64'(rsp_err), 64'(ee));
        check("rsp_rdata", 64'(rsp_rdata), 64'(er));
        check("we_pulses", 64'(we_pulses - p0), 64'(we && !ee));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er;
        logic        ee;
        int          p0;
        int          diffs;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        req_valid  = 2'b11;
        req_we     = 2'b00;
        req_signed = 2'b00;
        req_size   = '0;
        req_addr   = '0;
        req_wdata  = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_size", 64'(mem_size), 64'd0);
        check("rst_mem_wd", 64'(mem_wd), 64'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: store/load word, byte/half extension.
        xact(0, 1'b1, 1'b0, 2'b11, 32'h10, 32'hDEADBEEF);
        xact(0, 1'b0, 1'b0, 2'b11, 32'h10, 32'h0);
        check("ld_word", 64'(rsp_rdata), 64'hDEADBEEF);
        xact(0, 1'b0, 1'b1, 2'b00, 32'h10, 32'h0);
        check("ld_byte_s", 64'(rsp_rdata), 64'hFFFFFFEF);
        xact(0, 1'b0, 1'b0, 2'b00, 32'h10, 32'h0);
        check("ld_byte_u", 64'(rsp_rdata), 64'h000000EF);
        xact(0, 1'b0, 1'b1, 2'b01, 32'h12, 32'h0);
        check("ld_half_s", 64'(rsp_rdata), 64'hFFFFDEAD);

        // Errors and boundary cases.
        xact(0, 1'b1, 1'b0, 2'b11, 32'hFE, 32'h11223344);
        check("err_range", 64'(rsp_err), 64'd1);
        xact(1, 1'b1, 1'b0, 2'b10, 32'h30, 32'h55667788);
        check("err_size", 64'(rsp_err), 64'd1);
        xact(1, 1'b1, 1'b0, 2'b00, 32'hFF, 32'h000000A5);
        xact(0, 1'b0, 1'b0, 2'b11, 32'hFC, 32'h0);
        xact(1, 1'b1, 1'b0, 2'b01, 32'h21, 32'h0000CAFE);
        xact(0, 1'b0, 1'b0, 2'b11, 32'h20, 32'h0);

        // Both requesters continuously valid: alternating grants, 3 cycles apart.
        do_reset();
        req_we     = 2'b00;
        req_signed = 2'b00;
        req_size[0] = 2'b11;
        req_addr[0] = 32'h10;
        req_size[1] = 2'b00;
        req_addr[1] = 32'h11;
        req_valid   = 2'b11;
        #1;
        for (int g = 0; g < 6; g++) begin
            ref_access(1'b0, 1'b0, req_size[g % 2], req_addr[g % 2], 32'h0, er, ee);
            check("rr_grant", 64'(req_ready), 64'(2'b01 << (g % 2)));
            @(negedge clk); #1;
            check("rr_busy", 64'(req_ready), 64'd0);
            @(negedge clk); #1;
            check("rr_rsp_owner", 64'(rsp_valid), 64'(2'b01 << (g % 2)));
            check("rr_rdata", 64'(rsp_rdata), 64'(er));
            @(negedge clk); #1;
        end
        req_valid = 2'b00;
        @(negedge clk);
        repeat (3) @(negedge clk);

        // Randomized accesses checked against the reference.
        for (int k = 0; k < 40; k++) begin
            xact(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 2'($urandom),
                 (k % 4 == 0) ? 32'($urandom_range(248, 255)) : 32'($urandom_range(0, 255)),
                 $urandom);
        end

        // Reset during ACCESS of a store: dropped, no response, requester 0 wins next tie.
        do_reset();
        xact(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        p0 = we_pulses;
        req_we[0]    = 1'b1;
        req_size[0]  = 2'b11;
        req_addr[0]  = 32'h40;
        req_wdata[0] = 32'h12345678;
        req_valid[0] = 1'b1;
        #1;
        check("rstacc_grant", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstacc_we", 64'(mem_we), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("rstacc_rsp", 64'(rsp_valid), 64'd0);
        end
        check("rstacc_pulses", 64'(we_pulses - p0), 64'd0);
        rst_n = 1'b1;
        req_we = 2'b00;
        req_valid = 2'b11;
        #1;
        check("rstacc_tie", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);

        diffs = 0;
        for (int i = 0; i < 256; i++) if (m[i] !== ref_mem[i]) diffs++;
        check("mem_image", 64'(diffs), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Two-requester arbiter and access sequencer in front of the byte-addressed `data_memory`.
- Shares the single memory port between requester 0 (core load/store unit) and requester 1 (debug/loader port) using round-robin arbitration.
- Drives the memory's write enable, address, size and write data, captures read data, and applies load zero/sign extension.
- Returns a one-cycle response with an error flag for illegal accesses.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of requests and memory port
- DATA_WIDTH, 32, data width; fixed at 4 bytes
- MEM_BYTES, 256, memory size in bytes, used for range checking

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  2  request valid, one bit per requester
- req_ready  out  2  request accepted this cycle, one-hot or zero
- req_we  in  2  1 = store, 0 = load
- req_signed  in  2  load extension: 1 = sign-extend, 0 = zero-extend
- req_size  in  2x2  00 byte, 01 half, 11 word, 10 illegal
- req_addr  in  2xADDR_WIDTH  byte address
- req_wdata  in  2xDATA_WIDTH  store data, LSB-aligned
- rsp_valid  out  2  response pulse to the owning requester
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  access rejected
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_size  out  2  memory operation_byte_size
- mem_wd  out  DATA_WIDTH  memory write data
- mem_rd  in  DATA_WIDTH  memory read data, combinational from mem_addr

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant one valid requester and assert its req_ready combinationally.
  - On that cycle, latch we/signed/size/addr/wdata and the owner, then go to ACCESS.
  - With no valid request, stay in IDLE.
- Round-robin:
  - When both requesters are valid, grant the one not granted last.
  - When only one is valid, grant it.
  - The last-grant register updates on every grant.
- ACCESS:
  - mem_addr, mem_size and mem_wd are driven from the latched request.
  - For a legal store, mem_we=1 for exactly this cycle.
  - For a legal load, capture mem_rd and extend it: byte from bits [7:0], half from bits [15:0], word unchanged.
  - Compute the error flag.
  - Go to RESP.
- RESP:
  - rsp_valid[owner]=1 for one cycle, with rsp_rdata and rsp_err held stable.
  - There is no backpressure.
  - Go to IDLE.
- Errors, always checked:
  - size 10;
  - addr + bytes > MEM_BYTES, where bytes = 1, 2 or 4.
  - On error: mem_we is held 0, rsp_err=1, rsp_rdata=0.
- Outside ACCESS: mem_we=0; mem_addr, mem_size and mem_wd hold their last latched values.
- Requesters hold valid and payload stable until ready. Payload changes while not granted are legal and are ignored.

## Timing
- Request accepted at cycle N; memory access at N+1; rsp_valid at N+2.
- Next acceptance no earlier than N+3.
- Sustained throughput: one access per 3 cycles.
- req_ready is never asserted in ACCESS or RESP.
- A store's data is visible to a load accepted at N+3 or later.
- Reset values:
  - state IDLE;
  - req_ready=0 while rst_n=0;
  - rsp_valid=00, rsp_err=0, rsp_rdata=0;
  - mem_we=0, mem_addr=0, mem_size=00, mem_wd=0;
  - last-grant=1, so requester 0 wins the first tie.
- Reset asserted in ACCESS or RESP:
  - the pending access is dropped;
  - mem_we=0 on that edge's cycle and no write occurs;
  - no response is issued.
- Both requesters continuously valid: grants alternate 0,1,0,1.

## Configuration
- Macro: DMEM_ARBITER_ALIGN_CHECK_EN.
- Defined: a half access at an odd address or a word access with addr[1:0]≠0 is also an error (no write, rsp_err=1, rdata=0).
- Undefined: misaligned accesses pass through to memory, which handles unaligned byte lanes natively; no alignment error.

## Structure
- Package dmem_arb_pkg:
  - FSM state enum;
  - size encodings (SZ_BYTE=00, SZ_HALF=01, SZ_WORD=11);
  - bytes-per-size function;
  - load-extension function.
- Sub-module rr_arbiter2: two-input round-robin grant with a last-grant register, advanced by an accept pulse.

## Test plan
- Requester 0 stores word 0xDEADBEEF at 0x10, then loads word from 0x10:
  - one mem_we pulse at N+1;
  - load response rdata=0xDEADBEEF, err=0, at acceptance+2.
- After the above, load byte at 0x10 signed, then unsigned:
  - signed: rdata=0xFFFFFFEF;
  - unsigned: rdata=0x000000EF;
  - half at 0x12 signed: rdata=0xFFFFDEAD.
- Both requesters valid continuously for 6 grants:
  - grants 0,1,0,1,0,1;
  - each rsp_valid only on the owner's bit, exactly 3 cycles apart.
- Store word at 0xFE, and a request with size 10:
  - rsp_err=1, no mem_we pulse, memory contents unchanged.
- Store half at 0x21:
  - macro defined: rsp_err=1, no write;
  - macro undefined: bytes 0x21–0x22 written, err=0.
- rst_n low during ACCESS of a store:
  - no mem_we pulse, no rsp_valid;
  - after release, requester 0 wins a tie.
